// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front end.
package mips_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_WAIT = 2'd1,
        F_DROP = 2'd2
    } fetch_state_t;

    // One buffered fetch: the word and the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] word;
    } fetch_entry_t;

    localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and a registered head output (zero when empty).
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         head_valid,
    output logic [WIDTH-1:0]             head_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr_n;
    logic [AW-1:0]    wr_ptr_n;
    logic [CW-1:0]    count_n;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] head_n;

    // Next pointers/count; head is precomputed so the output stays a flop.
    always_comb begin
        do_pop   = pop && !flush && (count != '0);
        do_push  = push && !flush && ((count != CW'(DEPTH)) || do_pop);
        rd_ptr_n = flush ? '0 : rd_ptr + AW'(do_pop);
        wr_ptr_n = flush ? '0 : wr_ptr + AW'(do_push);
        count_n  = flush ? '0 : count + CW'(do_push) - CW'(do_pop);
        if (count_n == '0) begin
            head_n = '0;
        end else if (do_push && (wr_ptr == rd_ptr_n)) begin
            head_n = push_data;
        end else begin
            head_n = mem[rd_ptr_n];
        end
    end

    // Entry storage; contents are don't-care until counted in.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            rd_ptr     <= rd_ptr_n;
            wr_ptr     <= wr_ptr_n;
            count      <= count_n;
            head_valid <= (count_n != '0);
            head_data  <= head_n;
        end
    end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch: one-outstanding memory requester feeding a decode FIFO.
module ifetch_queue
    import mips_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clock,
    input  logic            reset,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            inst_ready
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_state_t    state;
    fetch_state_t    state_n;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] fetch_pc_n;
    logic [XLEN-1:0] mem_addr_n;
    logic [XLEN-1:0] target_pc;
    logic            mem_req_n;
    logic            ack;
    logic            push;
    logic            pop;
    logic            has_space;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_n;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    // Handshake terms and FIFO credit; redirect suppresses push and pop.
    always_comb begin
        target_pc       = redirect_pc & ~XLEN'(WORD_BYTES - 1);
        ack             = mem_req && mem_ack;
        push            = ack && (state == F_WAIT) && !redirect;
        pop             = inst_valid && inst_ready && !redirect;
        count_n         = redirect ? '0 : count + CW'(push) - CW'(pop);
        has_space       = (count_n < CW'(DEPTH));
        push_entry.pc   = mem_addr;
        push_entry.word = mem_rdata;
    end

    // Fetch FSM next state, next fetch address and request outputs.
    always_comb begin
        state_n    = state;
        fetch_pc_n = fetch_pc;
        unique case (state)
            F_IDLE: begin
                if (redirect) begin
                    fetch_pc_n = target_pc;
                    state_n    = F_WAIT;
                end else if (has_space) begin
                    state_n = F_WAIT;
                end
            end
            F_WAIT: begin
                if (redirect) begin
                    fetch_pc_n = target_pc;
                    state_n    = ack ? F_WAIT : F_DROP;
                end else if (ack) begin
                    fetch_pc_n = fetch_pc + XLEN'(WORD_BYTES);
                    state_n    = has_space ? F_WAIT : F_IDLE;
                end
            end
            F_DROP: begin
                if (redirect) begin
                    fetch_pc_n = target_pc;
                end
                if (ack) begin
                    state_n = has_space ? F_WAIT : F_IDLE;
                end
            end
            default: state_n = F_IDLE;
        endcase
        mem_req_n  = (state_n != F_IDLE);
        // A dropping request keeps presenting its stale address until acked.
        mem_addr_n = (state_n == F_DROP) ? mem_addr : fetch_pc_n;
    end

    // FSM state, fetch PC and registered memory request.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= F_IDLE;
            fetch_pc <= RESET_PC;
            mem_addr <= RESET_PC;
            mem_req  <= 1'b0;
        end else begin
            state    <= state_n;
            fetch_pc <= fetch_pc_n;
            mem_addr <= mem_addr_n;
            mem_req  <= mem_req_n;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .push_data  (push_entry),
        .pop        (pop),
        .count      (count),
        .head_valid (inst_valid),
        .head_data  (head_entry)
    );

    assign inst    = head_entry.word;
    assign inst_pc = head_entry.pc;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: vector table, hand sequences and a fetch scoreboard.
module tb_ifetch_queue;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clock;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    ifetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clock       (clock),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_ready  (inst_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          rst;
        logic        ack;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        bit          chk;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } sb_t;

    int          checks = 0;
    int          errors = 0;
    vec_t        tv[$];
    sb_t         exp_q[$];
    bit          drop_pending;
    bit          prev_wait;
    logic [31:0] prev_addr;
    logic [31:0] exp_fetch;
    logic        last_acc;
    logic        last_req;
    logic [31:0] last_addr;

    function automatic logic [31:0] mword(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_F00D;
    endfunction

    function automatic vec_t row(input bit rst, input logic ack, input logic rdy,
                                 input logic redir, input logic [31:0] rpc,
                                 input logic req, input logic [31:0] addr,
                                 input logic v, input logic [31:0] pc);
        vec_t r;
        r.rst = rst; r.ack = ack; r.rdy = rdy; r.redir = redir; r.rpc = rpc;
        r.chk = 1'b1; r.exp_req = req; r.exp_addr = addr; r.exp_valid = v; r.exp_pc = pc;
        return r;
    endfunction

    function automatic vec_t drv(input logic ack, input logic rdy,
                                 input logic redir, input logic [31:0] rpc);
        vec_t r;
        r = row(1'b0, ack, rdy, redir, rpc, 1'b0, 32'h0, 1'b0, 32'h0);
        r.chk = 1'b0;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; mem_ack = 1'b0; inst_ready = 1'b0;
        redirect = 1'b0; redirect_pc = 32'h0; mem_rdata = 32'h0;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        exp_q.delete();
        drop_pending = 1'b0;
        prev_wait    = 1'b0;
        exp_fetch    = RST_PC;
    endtask

    // Compare DUT outputs with the scoreboard head and request-hold rule.
    task automatic sb_check();
        check("sb_inst_valid", 32'(inst_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("sb_inst_pc", inst_pc, exp_q[0].pc);
            check("sb_inst", inst, exp_q[0].word);
        end else begin
            check("sb_empty_inst_pc", inst_pc, 32'h0);
            check("sb_empty_inst", inst, 32'h0);
        end
        if (prev_wait) begin
            check("hold_mem_req", 32'(mem_req), 32'h1);
            check("hold_mem_addr", mem_addr, prev_addr);
        end
    endtask

    // Advance the expected stream with the inputs just driven.
    task automatic sb_update();
        if (redirect) begin
            exp_q.delete();
            if (mem_req && mem_ack) drop_pending = 1'b0;
            else if (mem_req)       drop_pending = 1'b1;
            exp_fetch = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            if (exp_q.size() != 0 && inst_ready) void'(exp_q.pop_front());
            if (mem_req && mem_ack) begin
                if (drop_pending) begin
                    drop_pending = 1'b0;
                end else begin
                    sb_t e;
                    check("fetch_addr", mem_addr, exp_fetch);
                    e.pc   = mem_addr;
                    e.word = mword(mem_addr);
                    exp_q.push_back(e);
                    exp_fetch = exp_fetch + 32'd4;
                end
            end
        end
        prev_wait = mem_req && !mem_ack;
        prev_addr = mem_addr;
    endtask

    task automatic step(input vec_t v);
        @(negedge clock);
        sb_check();
        if (v.chk) begin
            check("tv_mem_req", 32'(mem_req), 32'(v.exp_req));
            if (v.exp_req) check("tv_mem_addr", mem_addr, v.exp_addr);
            check("tv_inst_valid", 32'(inst_valid), 32'(v.exp_valid));
            if (v.exp_valid) check("tv_inst_pc", inst_pc, v.exp_pc);
        end
        mem_ack     = v.ack;
        inst_ready  = v.rdy;
        redirect    = v.redir;
        redirect_pc = v.rpc;
        mem_rdata   = (v.ack && mem_req) ? mword(mem_addr) : 32'hDEAD_BEEF;
        last_acc    = mem_req && v.ack;
        last_req    = mem_req;
        last_addr   = mem_addr;
        sb_update();
    endtask

    initial begin
        int n;
        logic [31:0] first_addr;
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0; redirect = 1'b0;
        redirect_pc = 32'h0; inst_ready = 1'b0;

        // rst ack rdy redir rpc | req addr valid pc (outputs seen before driving)
        // Streaming: ack and pop every cycle.
        tv.push_back(row(1, 1, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0));
        tv.push_back(row(0, 1, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0));
        tv.push_back(row(0, 1, 1, 0, 32'h0,        1, 32'h4,        1, 32'h0));
        tv.push_back(row(0, 1, 1, 0, 32'h0,        1, 32'h8,        1, 32'h4));
        tv.push_back(row(0, 1, 1, 0, 32'h0,        1, 32'hC,        1, 32'h8));
        tv.push_back(row(0, 0, 1, 0, 32'h0,        1, 32'h10,       1, 32'hC));
        tv.push_back(row(0, 0, 1, 0, 32'h0,        1, 32'h10,       0, 32'h0));
        // Redirect during an unacked request; stale ack three cycles later.
        tv.push_back(row(1, 0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0));
        tv.push_back(row(0, 1, 1, 0, 32'h0,        1, 32'h0,        0, 32'h0));
        tv.push_back(row(0, 0, 1, 0, 32'h0,        1, 32'h4,        1, 32'h0));
        tv.push_back(row(0, 0, 1, 1, 32'h103,      1, 32'h4,        0, 32'h0));
        tv.push_back(row(0, 0, 1, 0, 32'h0,        1, 32'h4,        0, 32'h0));
        tv.push_back(row(0, 0, 1, 0, 32'h0,        1, 32'h4,        0, 32'h0));
        tv.push_back(row(0, 1, 1, 0, 32'h0,        1, 32'h4,        0, 32'h0));
        tv.push_back(row(0, 1, 1, 0, 32'h0,        1, 32'h100,      0, 32'h0));
        tv.push_back(row(0, 1, 1, 0, 32'h0,        1, 32'h104,      1, 32'h100));
        tv.push_back(row(0, 0, 1, 0, 32'h0,        1, 32'h108,      1, 32'h104));
        // Redirect with ack and pop together, then redirect to the top word and wrap.
        tv.push_back(row(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0));
        tv.push_back(row(0, 1, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0));
        tv.push_back(row(0, 1, 0, 0, 32'h0,        1, 32'h4,        1, 32'h0));
        tv.push_back(row(0, 1, 0, 0, 32'h0,        1, 32'h8,        1, 32'h0));
        tv.push_back(row(0, 1, 1, 1, 32'h2000,     1, 32'hC,        1, 32'h0));
        tv.push_back(row(0, 0, 1, 0, 32'h0,        1, 32'h2000,     0, 32'h0));
        tv.push_back(row(0, 1, 1, 0, 32'h0,        1, 32'h2000,     0, 32'h0));
        tv.push_back(row(0, 1, 1, 1, 32'hFFFF_FFFE, 1, 32'h2004,    1, 32'h2000));
        tv.push_back(row(0, 1, 1, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, 32'h0));
        tv.push_back(row(0, 1, 1, 0, 32'h0,        1, 32'h0,        1, 32'hFFFF_FFFC));
        tv.push_back(row(0, 0, 1, 0, 32'h0,        1, 32'h4,        1, 32'h0));
        tv.push_back(row(0, 0, 1, 0, 32'h0,        1, 32'h4,        0, 32'h0));
        // Full FIFO in idle: redirect with pop and a spurious ack.
        tv.push_back(row(1, 0, 0, 0, 32'h0,        0, 32'h0,        0, 32'h0));
        tv.push_back(row(0, 1, 0, 0, 32'h0,        1, 32'h0,        0, 32'h0));
        tv.push_back(row(0, 1, 0, 0, 32'h0,        1, 32'h4,        1, 32'h0));
        tv.push_back(row(0, 1, 0, 0, 32'h0,        1, 32'h8,        1, 32'h0));
        tv.push_back(row(0, 1, 0, 0, 32'h0,        1, 32'hC,        1, 32'h0));
        tv.push_back(row(0, 1, 1, 1, 32'h40,       0, 32'h0,        1, 32'h0));
        tv.push_back(row(0, 0, 1, 0, 32'h0,        1, 32'h40,       0, 32'h0));
        tv.push_back(row(0, 1, 1, 0, 32'h0,        1, 32'h40,       0, 32'h0));
        tv.push_back(row(0, 0, 1, 0, 32'h0,        1, 32'h44,       1, 32'h40));

        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].rst) do_reset();
            step(tv[i]);
        end

        // Back-pressure: exactly DEPTH fetches, then one credit buys one fetch.
        do_reset();
        n = 0;
        for (int i = 0; i < 8; i++) begin
            step(drv(1, 0, 0, 32'h0));
            if (last_acc) n++;
        end
        check("fill_acks", 32'(n), 32'(DEPTH));
        check("fill_req_low", 32'(last_req), 32'h0);
        step(drv(1, 1, 0, 32'h0));
        check("refill_idle_req", 32'(last_req), 32'h0);
        n = 0;
        first_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 6; i++) begin
            step(drv(1, 0, 0, 32'h0));
            if (last_acc) begin
                n++;
                first_addr = last_addr;
            end
        end
        check("refill_one_req", 32'(n), 32'h1);
        check("refill_addr", first_addr, 32'h10);

        // Random traffic with occasional redirects, checked by the scoreboard.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic a, r, d;
            a = ($urandom_range(2) != 0);
            r = ($urandom_range(1) != 0);
            d = ($urandom_range(19) == 0);
            step(drv(a, r, d, $urandom()));
        end

        // Asynchronous reset in the middle of an outstanding request.
        do_reset();
        step(drv(0, 0, 0, 32'h0));
        step(drv(1, 0, 0, 32'h0));
        step(drv(0, 0, 0, 32'h0));
        @(negedge clock);
        check("pre_arst_req", 32'(mem_req), 32'h1);
        check("pre_arst_valid", 32'(inst_valid), 32'h1);
        #2 reset = 1'b1;
        #1;
        check("arst_mem_req", 32'(mem_req), 32'h0);
        check("arst_inst_valid", 32'(inst_valid), 32'h0);
        check("arst_mem_addr", mem_addr, RST_PC);
        check("arst_inst", inst, 32'h0);
        check("arst_inst_pc", inst_pc, 32'h0);
        do_reset();
        step(row(0, 0, 1, 0, 32'h0, 0, 32'h0,  0, 32'h0));
        step(row(0, 1, 1, 0, 32'h0, 1, RST_PC, 0, 32'h0));
        step(row(0, 0, 1, 0, 32'h0, 1, 32'h4,  1, RST_PC));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
